// File: rtl/univ_shift_reg_n_if.sv
// Bus bundle for univ_shift_reg_n: control/data inputs from the master, register view back.
// The master drives mode, data and burst requests; the slave (the shifter) returns contents and status.
interface univ_shift_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       s;
    logic [WIDTH-1:0] i;
    logic             sr;
    logic             sl;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output en, s, i, sr, sl, start, cnt,
        input  a, so_r, so_l, busy, done
    );

    modport slave (
        input  en, s, i, sr, sl, start, cnt,
        output a, so_r, so_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg_n.sv
// N-bit universal shift register with single-step modes and a counted burst-shift engine.
// Optional macro USR_PARITY_EN adds output par = XOR-reduction of the register.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  clr,
`ifdef USR_PARITY_EN
    output logic                  par,
`endif
    univ_shift_reg_n_if.slave     bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             ser_r,
        input logic             ser_l
    );
        logic signed [WIDTH-1:0] cur_s;
        logic [WIDTH-1:0]        r;
        cur_s = signed'(cur);
        case (m)
            3'b001:  r = {ser_r, cur[WIDTH-1:1]};
            3'b010:  r = {cur[WIDTH-2:0], ser_l};
            3'b011:  r = ld;
            3'b100:  r = {cur[0], cur[WIDTH-1:1]};
            3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b110:  r = WIDTH'(cur_s >>> 1);
            default: r = cur;
        endcase
        return r;
    endfunction

    function automatic logic is_shift_mode(input logic [2:0] m);
        return m inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // start outranks en; a zero count completes immediately without touching a
                if (bus.start) begin
                    if (bus.cnt == '0) begin
                        done_d = 1'b1;
                    end else if (is_shift_mode(bus.s)) begin
                        mode_d  = bus.s;
                        rem_d   = bus.cnt;
                        state_d = BUSY;
                        busy_d  = 1'b1;
                    end else begin
                        a_d    = apply_mode(bus.s, a_q, bus.i, bus.sr, bus.sl);
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    a_d = apply_mode(bus.s, a_q, bus.i, bus.sr, bus.sl);
                end
            end
            BUSY: begin
                a_d   = apply_mode(mode_q, a_q, bus.i, bus.sr, bus.sl);
                rem_d = rem_q - CNT_W'(1);
                // Ending at a remaining count of one keeps the counter from ever wrapping
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched burst mode and count are only meaningful in BUSY, so they need no reset
    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        rem_q  <= rem_d;
    end

    assign bus.a    = a_q;
    assign bus.so_r = a_q[0];
    assign bus.so_l = a_q[WIDTH-1];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef USR_PARITY_EN
    assign par = ^a_q;
`endif

endmodule
